// File: rtl/crc32_d8_check.sv
// Gigabit Ethernet receive frame checker.
// Strips preamble/SFD, runs CRC32 over the frame including the FCS, checks
// the good-frame residue and frame length, and forwards the frame without
// its FCS. A one-cycle status pulse is emitted at the end of every frame.
module crc32_d8_check #(
  parameter int PRE_MIN = 1,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        dsin,
  input  logic [7:0]  din,
  output logic        dsout,
  output logic [7:0]  dout,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [10:0] frame_len
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] RESIDUE  = 32'hC704_DD7B;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [7:0]  PRE_REQ  = 8'(PRE_MIN);
  localparam logic [10:0] LEN_LO   = 11'(MIN_LEN);
  localparam logic [10:0] LEN_HI   = 11'(MAX_LEN);

  typedef enum logic [1:0] {GAP, IDLE, PRE, DATA} state_t;

  state_t      state;
  logic [7:0]  pre_cnt;
  logic [31:0] crc;
  logic [10:0] len;
  logic [7:0]  s0, s1, s2, s3;
  logic        crc_bad;
  logic        len_bad;

  // Byte-wide CRC32 step: MSB-first register, wire bit 0 of the byte first.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // End-of-frame verdicts, consumed only on the dsin-fall edge in DATA.
  always_comb begin
    crc_bad = (crc != RESIDUE);
    len_bad = (len < LEN_LO) || (len > LEN_HI);
  end

  // Frame FSM, CRC/length accumulation, payload output and status registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= GAP;
      pre_cnt    <= 8'd0;
      crc        <= CRC_INIT;
      len        <= 11'd0;
      dsout      <= 1'b0;
      dout       <= 8'd0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= 11'd0;
    end else begin
      frame_done <= 1'b0;
      dsout      <= 1'b0;
      dout       <= 8'd0;
      case (state)
        GAP: begin
          if (!dsin) state <= IDLE;
        end
        IDLE: begin
          if (dsin) begin
            if (din == PRE_BYTE) begin
              state   <= PRE;
              pre_cnt <= 8'd1;
            end else begin
              state <= GAP;
            end
          end
        end
        PRE: begin
          if (!dsin) begin
            state <= IDLE;
          end else if (din == PRE_BYTE) begin
            pre_cnt <= sat_inc8(pre_cnt);
          end else if (din == SFD_BYTE && pre_cnt >= PRE_REQ) begin
            state <= DATA;
            crc   <= CRC_INIT;
            len   <= 11'd0;
          end else begin
            state <= GAP;
          end
        end
        DATA: begin
          if (dsin) begin
            crc <= crc_next(crc, din);
            len <= sat_inc11(len);
            // Byte in s3 is released only once a later 4th byte exists,
            // so the trailing FCS never reaches dout.
            if (len >= 11'd4) begin
              dsout <= 1'b1;
              dout  <= s3;
            end
          end else begin
            state      <= IDLE;
            frame_done <= 1'b1;
            crc_err    <= crc_bad;
            len_err    <= len_bad;
            crc_ok     <= !crc_bad && !len_bad;
            frame_len  <= len;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

  // FCS-stripping delay line; held clear outside DATA so frames never mix.
  always_ff @(posedge sclk) begin
    if (state != DATA) begin
      s0 <= 8'd0;
      s1 <= 8'd0;
      s2 <= 8'd0;
      s3 <= 8'd0;
    end else if (dsin) begin
      s0 <= din;
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
  end

endmodule

// File: doc/crc32_d8_check.md
Name: crc32_d8_check

Overview:
- Gigabit Ethernet receive-side frame checker. It is the counterpart of the transmit CRC32 appender.
- Accepts the byte stream from the GMII/RGMII receive path with the preamble still attached.
- Detects the preamble and SFD, then runs CRC32 over every frame byte including the FCS and compares against the good-frame residue.
- Forwards the frame with preamble, SFD and FCS removed. Emits a one-cycle status pulse at the end of each frame for the downstream MAC parser.

Parameters:
PRE_MIN, 1, minimum number of 0x55 bytes required before the 0xD5 SFD
MIN_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive
MAX_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive

Ports:
sclk  input  1  byte clock, 125 MHz
rst  input  1  synchronous reset, active-high
dsin  input  1  receive data valid, high for the whole preamble+frame burst
din  input  8  receive byte, LSB-first bit order on the wire
dsout  output  1  payload valid; high for frame bytes excluding the FCS
dout  output  8  payload byte; 0 whenever dsout=0
frame_done  output  1  one-cycle pulse at the end of each frame that reached DATA
crc_ok  output  1  valid with frame_done: residue matched and length legal
crc_err  output  1  valid with frame_done: residue mismatch
len_err  output  1  valid with frame_done: frame_len < MIN_LEN or > MAX_LEN
frame_len  output  11  valid with frame_done: bytes after SFD incl. FCS, saturating at 2047

Behaviour:
- Single clock sclk. rst is synchronous and active-high.
- Reset values: dsout=0, dout=0, frame_done=0, crc_ok=0, crc_err=0, len_err=0, frame_len=0. CRC register=32'hFFFFFFFF. Byte counters=0.
- State after reset is GAP, not IDLE. This guarantees that a reset asserted mid-frame discards the remainder of that frame.
- FSM states: GAP, IDLE, PRE, DATA.
  - GAP: leave to IDLE on dsin=0.
  - IDLE: dsin=1 and din=0x55 -> PRE with pre_cnt=1. dsin=1 with any other byte -> GAP.
  - PRE: dsin=0 -> IDLE with no frame_done. din=0x55 -> stay, pre_cnt++ (saturating). din=0xD5 and pre_cnt>=PRE_MIN -> DATA with CRC=FFFFFFFF and len=0. Any other byte -> GAP.
  - DATA: each cycle with dsin=1, CRC updates from din and len increments, saturating at 2047. dsin=0 -> IDLE, and end-of-frame is evaluated on that same edge.
- CRC arithmetic:
  - The update equations and bit mapping are exactly those of the transmit CRC32 D8 generator, fed directly from din with no input register.
  - Good-frame residue is 32'hC704DD7B.
- End of frame (first dsin=0 cycle e in DATA): at edge e, frame_done<=1 for one cycle. At the same edge:
  - crc_err<=(crc!=C704DD7B)
  - len_err<=(len<MIN_LEN or len>MAX_LEN)
  - crc_ok<=!crc_err && !len_err
  - frame_len<=len
  - Status outputs hold their values until the next frame_done.
- FCS stripping uses a 4-byte delay line s0..s3, loaded only while in DATA with dsin=1.
  - A byte n sampled at cycle t appears on dout with dsout=1 in cycle t+5, provided byte n+4 exists (i.e. byte n is not one of the last 4).
  - The last 4 frame bytes (the FCS) are never output.
  - dsout falls in cycle e+1, coinciding with frame_done.
  - Frames shorter than 5 bytes produce no dsout. frame_done still fires, with len_err=1.
- Delay line is cleared on entry to DATA, so no bytes from a previous frame leak.
- dsin dropping at the exact SFD cycle gives PRE -> IDLE with no frame_done.
- Inter-frame gap of 1 cycle is legal. The next preamble may start in the cycle right after e: IDLE sees 0x55.
- Latency from dsin fall to frame_done: 1 cycle.

Test Plan:
- Good 64-byte frame: 7x55, D5, 60 payload bytes, correct FCS -> dout carries the 60 payload bytes with latency 5. frame_done pulses once with crc_ok=1, crc_err=0, len_err=0, frame_len=64.
- Same frame with one payload bit flipped -> 60 bytes forwarded, crc_err=1, crc_ok=0, frame_len=64.
- Loopback through the transmit CRC appender, with crc_err_en toggled between two frames -> first frame crc_ok=1, second frame crc_err=1.
- Runt: 7x55, D5, 3 bytes -> no dsout, frame_done with len_err=1, frame_len=3. Oversize frame of 1519 bytes with valid FCS -> len_err=1, crc_err=0, crc_ok=0.
- Preamble errors:
  - 55,55,AA,... -> no dsout, no frame_done until the next dsin low.
  - 55,55 followed by dsin low -> nothing emitted.
  - D5 as the first byte -> frame ignored.
- rst pulse for 1 cycle in the middle of DATA -> outputs zero the following cycle, rest of the burst ignored. A back-to-back good frame after a 1-cycle gap is then checked with crc_ok=1.
